// File: rtl/scu_pkg.sv
// Shared types for the SCU execute/memory stage.
// ALU op encodings, default width and stage FSM states.
package scu_pkg;

  localparam int DW_DEF = 32;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_NEG   = 3'd2,
    ALU_INC   = 3'd3,
    ALU_PASSA = 3'd4,
    ALU_PASSB = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/scu_alu.sv
// Combinational SCU ALU, modulo 2^DW.
// Reserved opcodes produce zero.
module scu_alu
  import scu_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [2:0]    alu_op,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          neg
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_NEG:   result = '0 - a;
      ALU_INC:   result = a + DW'(1);
      ALU_PASSA: result = a;
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[DW-1];

endmodule

// File: rtl/ex_mem_stage.sv
// SCU execute/memory stage: ALU, PC+imm adder and a
// handshaked LD/ST port that stalls upstream until done.
module ex_mem_stage
  import scu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int DW          = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          flush_i,
  input  logic [2:0]    alu_op,
  input  logic [DW-1:0] opA,
  input  logic [DW-1:0] opB,
  input  logic [DW-1:0] pc_i,
  input  logic [DW-1:0] imm_i,
  input  logic [5:0]    rd_i,
  input  logic          memRead_i,
  input  logic          memWrite_i,
  input  logic          memToReg_i,
  input  logic          regWrt_i,
  input  logic          svpc_i,
  output logic          stall_o,
  output logic          memToReg_o,
  output logic          regWrt_o,
  output logic          svpc_o,
  output logic [DW-1:0] dataMem_o,
  output logic [DW-1:0] ALU_o,
  output logic [DW-1:0] adder_o,
  output logic [5:0]    rd_o,
  output logic          zero_o,
  output logic          neg_o,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          err_o
);

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_e        state;
  logic [7:0]    cnt;
  logic [DW-1:0] rdata_q;
  logic          err_q;
  logic          flush_pend;

  logic [DW-1:0] alu_res;
  logic          alu_zero;
  logic          alu_neg;

  scu_alu #(.DW(DW)) u_alu (
    .alu_op (alu_op),
    .a      (opA),
    .b      (opB),
    .result (alu_res),
    .zero   (alu_zero),
    .neg    (alu_neg)
  );

  logic idle_st, wait_st, done_st;
  logic is_mem, mem_go, bubble, live, hold_wb;

  assign idle_st = (state == IDLE);
  assign wait_st = (state == WAIT);
  assign done_st = (state == DONE);
  assign is_mem  = memRead_i | memWrite_i;
  assign mem_go  = idle_st & in_valid & is_mem & !flush_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt        <= '0;
          flush_pend <= 1'b0;
          if (mem_go) state <= WAIT;
        end
        WAIT: begin
          // A flush only marks the result dead; the access runs on.
          if (flush_i) flush_pend <= 1'b1;
          if (dmem_ack) begin
            rdata_q <= dmem_rdata;
            state   <= DONE;
          end else if (cnt == CNT_LAST) begin
            err_q      <= 1'b1;
            flush_pend <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          cnt        <= '0;
          flush_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bubble  = done_st ? flush_pend : (!in_valid | flush_i);
  assign live    = !rst & !bubble;
  assign hold_wb = wait_st | mem_go;

  assign stall_o    = !rst & (wait_st | mem_go);
  assign regWrt_o   = live & !hold_wb & regWrt_i;
  assign memToReg_o = live & !hold_wb & memToReg_i;
  assign svpc_o     = live & !hold_wb & svpc_i;

  assign ALU_o   = live ? alu_res : '0;
  assign adder_o = live ? (pc_i + imm_i) : '0;
  assign rd_o    = live ? rd_i : '0;
  assign zero_o  = live & alu_zero;
  assign neg_o   = live & alu_neg;

  assign dataMem_o = (live & done_st & !memWrite_i) ? rdata_q : '0;

  assign dmem_req   = !rst & wait_st;
  assign dmem_we    = dmem_req & memWrite_i;
  assign dmem_addr  = dmem_req ? alu_res : '0;
  assign dmem_wdata = dmem_req ? opB : '0;
  assign err_o      = err_q;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Execute/memory stage of the 5-stage-less SCU pipeline.
- Sits between the ID/EX pipeline register and the EXWB register.
- Computes the ALU result and the PC+imm adder value, and performs LD/ST through a handshaked data-memory port.
- Stalls upstream until memory completes, then presents the memToReg/dataMem/ALU/regWrt/rd/adder/svpc bundle that EXWB latches.

Parameters:
- MEM_TIMEOUT, 15, WAIT cycles without dmem_ack before abort (2..255).
- DW, 32, datapath width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  ID/EX holds a real instruction.
- flush_i  in  1  kill current instruction (taken branch/jump).
- alu_op  in  3  0 ADD, 1 SUB, 2 NEG(-A), 3 INC(A+1), 4 PASSA, 5 PASSB, 6/7 → 0.
- opA, opB  in  DW  register operands.
- pc_i, imm_i  in  DW  for adder.
- rd_i  in  6  destination register.
- memRead_i, memWrite_i, memToReg_i, regWrt_i, svpc_i  in  1  control.
- stall_o  out  1  hold ID/EX and PC.
- memToReg_o, regWrt_o, svpc_o  out  1  to EXWB.
- dataMem_o, ALU_o, adder_o  out  DW  to EXWB.
- rd_o  out  6  to EXWB.
- zero_o, neg_o  out  1  ALU result ==0 / bit DW-1, for BRZ/BRN.
- dmem_req, dmem_we  out  1  memory request / write enable.
- dmem_addr, dmem_wdata  out  DW  address = ALU result; wdata = opB.
- dmem_ack  in  1  one-cycle completion pulse.
- dmem_rdata  in  DW  valid with ack.
- err_o  out  1  sticky memory timeout.

Behaviour:
- Reset (async, immediate): state IDLE, counter 0, rdata_q 0, err_o 0, flush_pend 0. While rst=1, every output is 0.
- ALU: combinational, modulo 2^DW, no overflow flag. adder_o = pc_i+imm_i (wraps). zero_o/neg_o derive from ALU_o.
- bubble = !in_valid | flush_i (IDLE) or flush_pend (DONE).
- On bubble: regWrt_o, memToReg_o, svpc_o, zero_o, neg_o = 0 and data outputs 0.
- FSM:
  - IDLE:
    - Non-memory op: outputs pass combinationally (0-cycle latency), stall_o=0, dmem_req=0.
    - in_valid & (memRead_i|memWrite_i) & !flush_i: stall_o=1, regWrt_o=0, next WAIT.
    - memRead_i & memWrite_i both set: treated as store.
  - WAIT:
    - dmem_req=1, dmem_we=memWrite_i, stall_o=1, regWrt_o=0. Address and wdata stay stable because inputs are held by the stall.
    - Counter increments each cycle.
    - dmem_ack: rdata_q←dmem_rdata, next DONE.
    - Counter reaches MEM_TIMEOUT-1 without ack: err_o←1, flush_pend←1, next DONE.
    - flush_i in WAIT sets flush_pend; the transaction is not aborted, and an in-flight store still completes.
  - DONE (1 cycle):
    - stall_o=0, dmem_req=0.
    - dataMem_o=rdata_q; other outputs from held inputs, unless flush_pend (then bubble).
    - Clear counter and flush_pend; next IDLE.
- Load latency: min 2 stall cycles (IDLE→WAIT→DONE with ack in first WAIT cycle); result written by EXWB on the edge ending DONE.
- dmem_ack outside WAIT is ignored.
- err_o clears only on reset. Later instructions continue normally.
- Reset mid-WAIT: request drops immediately, no retry.
- dataMem_o is 0 in IDLE, and in DONE for stores.

Decomposition:
- Shared package scu_pkg: alu_op encodings (ALU_ADD..ALU_PASSB), DW default, state enum {IDLE, WAIT, DONE}.
- Natural sub-module: scu_alu, combinational: alu_op, A, B → result, zero, neg.
- FSM, counter and output gating stay in ex_mem_stage.

Test Plan:
- ADD, opA=5, opB=7, regWrt_i=1, rd_i=3 → same cycle: ALU_o=12, regWrt_o=1, rd_o=3, stall_o=0, zero_o=0.
- NEG, opA=1 → ALU_o=32'hFFFFFFFF, neg_o=1. SUB, 9-9 → zero_o=1. pc_i=32'hFFFFFFFF, imm_i=2 → adder_o=1.
- LD, PASSA, opA=0x40, dmem_ack on 3rd WAIT cycle with rdata=0xCAFE → dmem_addr=0x40 for 3 cycles, stall_o high for 4 cycles, then DONE: dataMem_o=0xCAFE, memToReg_o=1, regWrt_o=1.
- ST, opA=0x10, opB=0xBEEF, flush_i pulsed in WAIT, ack after 2 cycles → dmem_we=1, wdata=0xBEEF held until ack; DONE outputs bubble (regWrt_o=0).
- LD with no ack → exactly MEM_TIMEOUT WAIT cycles, err_o=1 thereafter, regWrt_o=0 in DONE; next ADD proceeds normally.
- Assert rst during WAIT → dmem_req, stall_o, all outputs 0 asynchronously; after release, IDLE and late dmem_ack ignored.
